// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer (TH reload, TL count, TCON control) raising a level IRQ on overflow.
// Define TIMER_AUTO_ACK_EN to let the irq_ack pulse clear the pending status bit.
module timer_irq_source #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    input  logic        irq_ack,
    output logic        IRQ
);

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 16;
    localparam int unsigned AW = 30;
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE);
    localparam logic [AW-1:0] W_TH   = BASE_ADDR[31:2];
    localparam logic [AW-1:0] W_TL   = W_TH + AW'(1);
    localparam logic [AW-1:0] W_TCON = W_TH + AW'(2);

    logic [DW-1:0] th, th_n;
    logic [DW-1:0] tl, tl_n;
    logic [2:0]    tcon, tcon_n;
    logic [PW-1:0] pc, pc_n;

    logic sel_th, sel_tl, sel_tcon;
    logic wr_th, wr_tl, wr_tcon;
    logic tick, ovf;

    // Word decode; byte-lane bits are ignored
    assign sel_th   = (addr[31:2] == W_TH);
    assign sel_tl   = (addr[31:2] == W_TL);
    assign sel_tcon = (addr[31:2] == W_TCON);
    assign hit      = sel_th | sel_tl | sel_tcon;

    assign wr_th   = MemWr & sel_th;
    assign wr_tl   = MemWr & sel_tl;
    assign wr_tcon = MemWr & sel_tcon;

    assign tick = tcon[0] & (pc == PS_MAX);
    assign ovf  = tick & (tl == '1);

    assign IRQ = tcon[1] & tcon[2];

`ifdef TIMER_AUTO_ACK_EN
    logic unused_bits;
    assign unused_bits = ^addr[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], irq_ack};
`endif

    // Next-state: software writes override counting; an overflow set always survives a clear
    always_comb begin
        th_n   = th;
        tl_n   = tl;
        tcon_n = tcon;
        pc_n   = '0;

        if (tcon[0]) begin
            pc_n = tick ? '0 : pc + PW'(1);
        end

        if (tick) begin
            tl_n = ovf ? th : tl + DW'(1);
        end

        if (wr_th) begin
            th_n = wdata;
        end
        if (wr_tl) begin
            tl_n = wdata;
        end

`ifdef TIMER_AUTO_ACK_EN
        if (irq_ack) begin
            tcon_n[2] = 1'b0;
        end
`endif
        if (wr_tcon) begin
            tcon_n = wdata[2:0];
        end
        if (ovf && tcon[1]) begin
            tcon_n[2] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
            pc   <= '0;
        end else begin
            th   <= th_n;
            tl   <= tl_n;
            tcon <= tcon_n;
            pc   <= pc_n;
        end
    end

    // Zero-latency read of the pre-write register contents
    always_comb begin
        rdata = '0;
        if (!reset && MemRd) begin
            if (sel_th) begin
                rdata = th;
            end else if (sel_tl) begin
                rdata = tl;
            end else if (sel_tcon) begin
                rdata = {29'd0, tcon};
            end
        end
    end

endmodule

// File: tb/tb_timer_irq_source.sv
// Bench for timer_irq_source: two instances (PRESCALE 0 and 3) on a shared bus, checked against a register-level model.
module tb_timer_irq_source;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH = BASE;
    localparam logic [31:0] A_TL = BASE + 32'd4;
    localparam logic [31:0] A_TC = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset, MemRd, MemWr, irq_ack;
    logic [31:0] addr, wdata;
    logic [31:0] rdata0, rdata1;
    logic        hit0, hit1, irq0, irq1;

    always #5 clk = ~clk;

    timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE(0)) u_dut0 (
        .clk(clk), .reset(reset), .addr(addr), .MemRd(MemRd), .MemWr(MemWr),
        .wdata(wdata), .rdata(rdata0), .hit(hit0), .irq_ack(irq_ack), .IRQ(irq0)
    );

    timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE(3)) u_dut1 (
        .clk(clk), .reset(reset), .addr(addr), .MemRd(MemRd), .MemWr(MemWr),
        .wdata(wdata), .rdata(rdata1), .hit(hit1), .irq_ack(irq_ack), .IRQ(irq1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural registers of each instance
    logic [31:0] m_th [2];
    logic [31:0] m_tl [2];
    logic [2:0]  m_ctl[2];
    int unsigned m_pc [2];
    int unsigned ps   [2] = '{0, 3};
    bit          model_ok = 1'b0;

    function automatic logic [31:0] word_off();
        return (addr >> 2) - (BASE >> 2);
    endfunction

    function automatic bit exp_hit();
        return word_off() < 32'd3;
    endfunction

    function automatic logic [31:0] exp_rdata(input int i);
        logic [31:0] off;
        off = word_off();
        if (reset || !MemRd) return 32'd0;
        if (off == 32'd0) return m_th[i];
        if (off == 32'd1) return m_tl[i];
        if (off == 32'd2) return {29'd0, m_ctl[i]};
        return 32'd0;
    endfunction

    task automatic model_update();
        bit          tick, ovf, wsel, st;
        logic [31:0] off, nth, ntl;
        logic [1:0]  ctl_lo;
        int unsigned npc;
        off  = word_off();
        wsel = MemWr && exp_hit();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_th[i] = 0; m_tl[i] = 0; m_ctl[i] = 0; m_pc[i] = 0;
            end else if (model_ok) begin
                tick = m_ctl[i][0] && (m_pc[i] == ps[i]);
                ovf  = tick && (m_tl[i] == 32'hFFFF_FFFF);
                npc  = (m_ctl[i][0] && !tick) ? m_pc[i] + 1 : 0;
                nth  = m_th[i];
                ntl  = m_tl[i];
                if (tick) ntl = ovf ? m_th[i] : m_tl[i] + 32'd1;
                if (wsel && off == 32'd0) nth = wdata;
                if (wsel && off == 32'd1) ntl = wdata;
                st     = m_ctl[i][2];
                ctl_lo = m_ctl[i][1:0];
`ifdef TIMER_AUTO_ACK_EN
                if (irq_ack) st = 1'b0;
`endif
                if (wsel && off == 32'd2) begin
                    st     = wdata[2];
                    ctl_lo = wdata[1:0];
                end
                if (ovf && m_ctl[i][1]) st = 1'b1;
                m_th[i]  = nth;
                m_tl[i]  = ntl;
                m_ctl[i] = {st, ctl_lo};
                m_pc[i]  = npc;
            end
        end
        if (reset) model_ok = 1'b1;
    endtask

    // One bus cycle: compare all outputs against the model, advance the model, cross the edge
    task automatic step();
        #2;
        if (model_ok) begin
            check_eq("rdata0", rdata0, exp_rdata(0));
            check_eq("rdata1", rdata1, exp_rdata(1));
            check_eq("hit0", 32'(hit0), 32'(exp_hit()));
            check_eq("hit1", 32'(hit1), 32'(exp_hit()));
            check_eq("irq0", 32'(irq0), 32'(m_ctl[0][1] & m_ctl[0][2]));
            check_eq("irq1", 32'(irq1), 32'(m_ctl[1][1] & m_ctl[1][2]));
        end
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d, input bit ack);
        MemRd = rd; MemWr = wr; addr = a; wdata = d; irq_ack = ack;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        drive(0, 1, a, d, 0);
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 0, 32'd0, 32'd0, 0);
            step();
        end
    endtask

    // Directed read of one instance with a fixed expected value
    task automatic rd_chk(input string tag, input int which, input logic [31:0] a, input logic [31:0] exp);
        drive(1, 0, a, 32'd0, 0);
        #1;
        check_eq(tag, (which == 0) ? rdata0 : rdata1, exp);
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 32'd0, 32'd0, 0);
        idle(2);
        reset = 1'b0;

        // Reset values and decode
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, BASE + 32'(4 * k), 32'd0, 0);
            #1;
            check_eq("t1_rdata", rdata0, 32'd0);
            check_eq("t1_hit", 32'(hit0), 32'd1);
            step();
        end
        drive(1, 0, BASE + 32'd12, 32'd0, 0);
        #1;
        check_eq("t1_hit_off", 32'(hit0), 32'd0);
        check_eq("t1_irq", 32'(irq0), 32'd0);
        step();

        // Overflow reload and IRQ
        bus_wr(A_TH, 32'hFFFF_FFFC);
        bus_wr(A_TL, 32'hFFFF_FFFE);
        bus_wr(A_TC, 32'd3);
        rd_chk("t2_tl_a", 0, A_TL, 32'hFFFF_FFFE);
        rd_chk("t2_tl_b", 0, A_TL, 32'hFFFF_FFFF);
        drive(1, 0, A_TL, 32'd0, 0);
        #1;
        check_eq("t2_reload", rdata0, 32'hFFFF_FFFC);
        check_eq("t2_irq_hi", 32'(irq0), 32'd1);
        step();
        bus_wr(A_TC, 32'd3);
        drive(0, 0, 32'd0, 32'd0, 0);
        #1;
        check_eq("t2_irq_lo", 32'(irq0), 32'd0);
        step();

        // Prescaled counting and freeze
        bus_wr(A_TC, 32'd0);
        bus_wr(A_TL, 32'd0);
        bus_wr(A_TC, 32'd1);
        idle(4);
        rd_chk("t3_tl1", 1, A_TL, 32'd1);
        idle(3);
        rd_chk("t3_tl2", 1, A_TL, 32'd2);
        bus_wr(A_TC, 32'd0);
        idle(20);
        rd_chk("t3_frozen", 1, A_TL, 32'd2);

        // Same-cycle priorities
        bus_wr(A_TH, 32'h10);
        bus_wr(A_TL, 32'hFFFF_FFFE);
        bus_wr(A_TC, 32'd3);
        idle(1);
        bus_wr(A_TC, 32'd3);
        drive(1, 0, A_TC, 32'd0, 0);
        #1;
        check_eq("t4_tcon", rdata0, 32'd7);
        check_eq("t4_irq", 32'(irq0), 32'd1);
        step();
        bus_wr(A_TL, 32'd5);
        rd_chk("t4_tl_wr", 0, A_TL, 32'd5);

        // Interrupt acknowledge
        drive(0, 0, 32'd0, 32'd0, 1);
        step();
        drive(1, 0, A_TC, 32'd0, 0);
        #1;
`ifdef TIMER_AUTO_ACK_EN
        check_eq("t5_tcon", rdata0, 32'd3);
        check_eq("t5_irq", 32'(irq0), 32'd0);
`else
        check_eq("t5_tcon", rdata0, 32'd7);
        check_eq("t5_irq", 32'(irq0), 32'd1);
`endif
        step();

        // Reset with IRQ pending mid-count
        bus_wr(A_TC, 32'd7);
        bus_wr(A_TL, 32'd1234);
        reset = 1'b1;
        drive(1, 0, A_TC, 32'd0, 0);
        #1;
        check_eq("t6_rd_in_reset", rdata0, 32'd0);
        step();
        reset = 1'b0;
        rd_chk("t6_th", 0, A_TH, 32'd0);
        rd_chk("t6_tl", 0, A_TL, 32'd0);
        drive(1, 0, A_TC, 32'd0, 0);
        #1;
        check_eq("t6_tcon", rdata0, 32'd0);
        check_eq("t6_irq", 32'(irq0), 32'd0);
        step();
        idle(3);
        rd_chk("t6_tl_hold", 0, A_TL, 32'd0);

        // Randomized traffic checked cycle by cycle against the model
        for (int n = 0; n < 3000; n++) begin
            int unsigned sel;
            logic [31:0] a, d;
            reset = ($urandom_range(0, 199) == 0);
            sel   = $urandom_range(0, 4);
            if (sel < 3) a = BASE + 32'(4 * sel) + 32'($urandom_range(0, 3));
            else if (sel == 3) a = BASE + 32'd12;
            else a = $urandom;
            d = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a, d,
                  ($urandom_range(0, 7) == 0));
            step();
        end
        reset = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
